// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-locked arbiter sharing one async FIFO write port among NUM_REQ sources
module fifo_wr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST = 8,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [ID_WIDTH-1:0]           fifo_src,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state;
    logic [ID_WIDTH-1:0] gnt_id, rr_ptr, sel_id;
    logic [7:0] beat_cnt;
    logic sel_ok, xfer, release_now;
    // Scan downward so the closest source after rr_ptr overwrites farther ones.
    always_comb begin
        logic [ID_WIDTH-1:0] idx;
        idx = '0;
        sel_id = '0;
        sel_ok = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                sel_id = idx;
                sel_ok = 1'b1;
            end
        end
    end
    always_comb begin
        busy = state == GRANT;
        xfer = busy && req_valid[gnt_id] && !fifo_full;
        release_now = req_last[gnt_id] || beat_cnt == 8'(MAX_BURST - 1);
        req_ready = busy && !fifo_full ? grant : '0;
        fifo_w_en = xfer;
        fifo_data_in = xfer ? req_data[gnt_id*DATA_WIDTH +: DATA_WIDTH] : '0;
        fifo_src = xfer ? gnt_id : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            gnt_id <= '0;
            rr_ptr <= ID_WIDTH'(NUM_REQ - 1);
            beat_cnt <= '0;
        end else if (state == IDLE) begin
            if (sel_ok) begin
                state <= GRANT;
                grant <= NUM_REQ'(1) << sel_id;
                gnt_id <= sel_id;
                beat_cnt <= '0;
            end
        end else if (xfer) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (release_now) begin
                state <= IDLE;
                grant <= '0;
                rr_ptr <= gnt_id;
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and randomized scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int MB = 8;
    localparam int DEPTH = 4096;
    logic clk, rst;
    logic [N-1:0] req_valid, req_last, req_ready, grant;
    logic [N*W-1:0] req_data;
    logic fifo_full, fifo_w_en, busy;
    logic [W-1:0] fifo_data_in;
    logic [1:0] fifo_src;
    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_w_en(fifo_w_en),
        .fifo_data_in(fifo_data_in), .fifo_src(fifo_src), .grant(grant), .busy(busy)
    );
    // per-source stimulus queues and matching expected-beat queues ({last, data})
    logic [8:0] sbeat [N][DEPTH];
    logic [8:0] ebeat [N][DEPTH];
    int s_head [N], s_tail [N], e_head [N], e_tail [N];
    int wlog[$];
    int n_cmp = 0, n_err = 0;
    logic [N-1:0] gap_mask = '0;
    logic full_force = 0, rnd_gap = 0, rnd_full = 0;
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    task automatic push_pkt(input int s, input int len, input logic [7:0] base, input bit rnd);
        for (int k = 0; k < len; k++) begin
            logic [8:0] b;
            b = {k == len - 1, rnd ? 8'($urandom) : base + 8'(k)};
            sbeat[s][s_tail[s]] = b;
            ebeat[s][e_tail[s]] = b;
            s_tail[s]++;
            e_tail[s]++;
        end
    endtask
    // source drivers: present head beat after each edge, retire it if accepted
    initial begin
        for (int i = 0; i < N; i++) begin
            s_head[i] = 0; s_tail[i] = 0; e_head[i] = 0; e_tail[i] = 0;
        end
        req_valid = '0; req_last = '0; req_data = '0; fifo_full = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                logic has;
                has = s_head[i] != s_tail[i];
                req_valid[i] = has && !gap_mask[i] && !(rnd_gap && $urandom_range(0, 3) == 0);
                req_last[i] = has ? sbeat[i][s_head[i]][8] : 1'b0;
                req_data[i*W +: W] = has ? sbeat[i][s_head[i]][7:0] : '0;
            end
            fifo_full = full_force || (rnd_full && $urandom_range(0, 3) == 0);
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (req_valid[i] && req_ready[i]) s_head[i]++;
        end
    end
    // monitor: transaction-level arbitration model plus per-source data scoreboard
    initial begin
        int m_gnt, m_rr, m_cnt, s;
        logic m_busy, xf, found;
        m_gnt = 0; m_rr = N - 1; m_cnt = 0; m_busy = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_gnt = 0; m_rr = N - 1; m_cnt = 0; m_busy = 0;
            end else begin
                xf = m_busy && req_valid[m_gnt] && !fifo_full;
                check("grant", grant, m_busy ? 32'(1 << m_gnt) : 0);
                check("busy", busy, m_busy);
                check("req_ready", req_ready, (m_busy && !fifo_full) ? 32'(1 << m_gnt) : 0);
                check("w_en", fifo_w_en, xf);
                if (fifo_w_en) begin
                    s = int'(fifo_src);
                    check("src", fifo_src, m_gnt);
                    check("w_en_full", fifo_full, 0);
                    check("sb_avail", e_head[s] != e_tail[s], 1);
                    if (e_head[s] != e_tail[s]) begin
                        check("data", fifo_data_in, ebeat[s][e_head[s]][7:0]);
                        e_head[s]++;
                    end
                    wlog.push_back(s);
                end else begin
                    check("idle_data", fifo_data_in, 0);
                    check("idle_src", fifo_src, 0);
                end
                if (!m_busy) begin
                    found = 0;
                    for (int k = 1; k <= N; k++)
                        if (!found && req_valid[(m_rr + k) % N]) begin
                            found = 1;
                            m_gnt = (m_rr + k) % N;
                        end
                    if (found) begin
                        m_busy = 1;
                        m_cnt = 0;
                    end
                end else if (xf) begin
                    m_cnt++;
                    if (req_last[m_gnt] || m_cnt == MB) begin
                        m_busy = 0;
                        m_rr = m_gnt;
                    end
                end
            end
        end
    end
    task automatic wait_idle(input int budget);
        logic done;
        done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            #1;
            done = !busy;
            for (int i = 0; i < N; i++) if (s_head[i] != s_tail[i]) done = 0;
        end
        check("drain_done", done, 1);
        repeat (2) @(negedge clk);
        #1;
    endtask
    task automatic wait_beats(input int s, input int target);
        for (int c = 0; c < 100 && s_head[s] != target; c++) begin
            @(negedge clk);
            #1;
        end
        check("beat_wait", s_head[s], target);
    endtask
    task automatic check_log(input string name, input int exp[$]);
        check({name, "_len"}, wlog.size(), exp.size());
        for (int k = 0; k < exp.size() && k < wlog.size(); k++) check(name, wlog[k], exp[k]);
        wlog.delete();
    endtask
    initial begin
        int exp[$];
        int t;
        rst = 0;
        #1 rst = 1;
        #1;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_w_en", fifo_w_en, 0);
        check("rst_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        #3 rst = 0;
        @(negedge clk);
        #1;
        // burst cap: src1 12 beats split 8/4 around src3's packet
        push_pkt(1, 12, 8'h10, 0);
        push_pkt(3, 3, 8'h30, 0);
        wait_idle(200);
        exp = {};
        for (int k = 0; k < 8; k++) exp.push_back(1);
        for (int k = 0; k < 3; k++) exp.push_back(3);
        for (int k = 0; k < 4; k++) exp.push_back(1);
        check_log("burst_order", exp);
        // single source src2, 3 beats
        push_pkt(2, 3, 8'hA1, 0);
        t = 0;
        while (grant == 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("single_grant", grant, 4'b0100);
        wait_idle(100);
        check_log("single_order", '{2, 2, 2});
        // full backpressure after beat 2 of 5
        t = s_tail[0];
        push_pkt(0, 5, 8'h50, 0);
        wait_beats(0, t + 2);
        full_force = 1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("full_ready", req_ready, 0);
            check("full_w_en", fifo_w_en, 0);
            check("full_grant", grant, 4'b0001);
        end
        full_force = 0;
        wait_idle(100);
        check_log("full_order", '{0, 0, 0, 0, 0});
        // valid gap on src1 while src0 requests
        t = s_tail[1];
        push_pkt(1, 4, 8'h60, 0);
        wait_beats(1, t + 2);
        gap_mask = 4'b0010;
        push_pkt(0, 1, 8'h70, 0);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("gap_grant", grant, 4'b0010);
            check("gap_w_en", fifo_w_en, 0);
        end
        gap_mask = '0;
        wait_idle(100);
        check_log("gap_order", '{1, 1, 1, 1, 0});
        // reset mid-packet
        t = s_tail[2];
        push_pkt(2, 4, 8'h80, 0);
        wait_beats(2, t + 2);
        rst = 1;
        #1;
        check("mid_rst_w_en", fifo_w_en, 0);
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_grant", grant, 0);
        for (int i = 0; i < N; i++) begin
            s_head[i] = s_tail[i];
            e_head[i] = e_tail[i];
        end
        wlog.delete();
        repeat (2) @(posedge clk);
        #3 rst = 0;
        // round robin, all sources with repeated 1-beat packets
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push_pkt(i, 1, 8'(8'hC0 + 16 * r + i), 0);
        wait_idle(200);
        check_log("rr_order", '{0, 1, 2, 3, 0, 1, 2, 3});
        // randomized traffic with valid gaps and full backpressure
        rnd_gap = 1;
        rnd_full = 1;
        for (int p = 0; p < 150; p++) begin
            push_pkt($urandom_range(0, N - 1), $urandom_range(1, 12), 8'h0, 1);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        wait_idle(20000);
        rnd_gap = 0;
        rnd_full = 0;
        for (int i = 0; i < N; i++) check("sb_drained", e_tail[i] - e_head[i], 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
